// File: rtl/decision_engine_mw.sv
// Picks the lowest-numbered unassigned variable from a free bitmap held in
// external memory, clears its bit with one read-modify-write, and reports it.
module decision_engine_mw #(
    parameter int VAR_NUM   = 32,
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 1,
    localparam int IDX_W    = $clog2(VAR_NUM)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              decision_en,
    input  logic              default_phase,
    output logic              mem_request,
    input  logic              mem_grant,
    output logic              data_read,
    output logic              data_write,
    output logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] wr_data,
    output logic [IDX_W-1:0]  var_out,
    output logic              assignment,
    output logic              decision_finish,
    output logic              all_assigned,
    output logic              busy
);

    localparam int WORDS = VAR_NUM / WORD_W;
    localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_SCAN  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              phase_q, phase_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  var_q, var_d;
    logic              asg_q, asg_d;
    logic              all_q, all_d;
    logic              req_q, req_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              fin_q, fin_d;
    logic              busy_q, busy_d;

    logic              hit_found;
    logic [BIT_W-1:0]  hit_bit;

    // Descending scan so the last match written is the lowest set bit.
    always_comb begin
        hit_found = 1'b0;
        hit_bit   = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (buf_q[i]) begin
                hit_found = 1'b1;
                hit_bit   = BIT_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        phase_d = phase_q;
        buf_d   = buf_q;
        var_d   = var_q;
        asg_d   = asg_q;
        all_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (decision_en) begin
                    ptr_d   = '0;
                    phase_d = default_phase;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_grant) begin
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                buf_d   = rd_data;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (hit_found) begin
                    var_d   = IDX_W'(ptr_q) * IDX_W'(WORD_W) + IDX_W'(hit_bit);
                    asg_d   = phase_q;
                    state_d = S_WRITE;
                end else if (ptr_q == LAST_PTR) begin
                    all_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = S_READ;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        req_d   = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_CAPT) ||
                  (state_d == S_SCAN) || (state_d == S_WRITE);
        rd_d    = (state_d == S_READ);
        wr_d    = (state_d == S_WRITE);
        addr_d  = (rd_d || wr_d) ? ADDR_W'(BASE_ADDR) + ADDR_W'(ptr_d) : '0;
        wdata_d = wr_d ? (buf_q & ~(WORD_W'(1) << hit_bit)) : '0;
        fin_d   = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            phase_q <= 1'b0;
            buf_q   <= '0;
            var_q   <= '0;
            asg_q   <= 1'b0;
            all_q   <= 1'b0;
            req_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            phase_q <= phase_d;
            buf_q   <= buf_d;
            var_q   <= var_d;
            asg_q   <= asg_d;
            all_q   <= all_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
        end
    end

    assign mem_request     = req_q;
    assign data_read       = rd_q;
    assign data_write      = wr_q;
    assign address         = addr_q;
    assign wr_data         = wdata_q;
    assign var_out         = var_q;
    assign assignment      = asg_q;
    assign decision_finish = fin_q;
    assign all_assigned    = all_q;
    assign busy            = busy_q;

endmodule
